// File: rtl/fir_coeff_ctrl.sv
// Double-buffered 5x5 FIR kernel store: a loader fills the shadow bank, and the
// active bank is swapped in atomically on the next vertical-sync rising edge.
module fir_coeff_ctrl #(
  parameter int NUM_COEFF = 25,
  parameter int COEFF_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_start,
  input  logic                         wr_valid,
  input  logic signed [COEFF_W-1:0]    wr_data,
  output logic                         wr_ready,
  input  logic                         vs_i,
  output logic [NUM_COEFF*COEFF_W-1:0] coeff_o,
  output logic                         busy,
  output logic                         pending,
  output logic                         update_done
);

  localparam int IDX_W = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
  localparam int CENTER = NUM_COEFF / 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFF - 1);
  localparam logic signed [COEFF_W-1:0] UNITY = COEFF_W'(16'h0100);

  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

  state_t                      state;
  logic [IDX_W-1:0]            idx;
  logic                        vs_p1;
  logic                        vs_rise;
  logic signed [COEFF_W-1:0]   shadow [NUM_COEFF];
  logic signed [COEFF_W-1:0]   active [NUM_COEFF];

  // Pass-through kernel: unity gain on the centre tap, zero elsewhere.
  function automatic logic signed [COEFF_W-1:0] identity_coeff(input int k);
    logic signed [COEFF_W-1:0] c;
    c = '0;
    if (k == CENTER) c = UNITY;
    return c;
  endfunction

  assign vs_rise = vs_i & ~vs_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      vs_p1       <= 1'b0;
      update_done <= 1'b0;
      for (int k = 0; k < NUM_COEFF; k++) begin
        shadow[k] <= '0;
        active[k] <= identity_coeff(k);
      end
    end else begin
      vs_p1       <= vs_i;
      update_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state <= LOAD;
            idx   <= '0;
          end
        end
        LOAD: begin
          if (wr_valid) begin
            shadow[idx] <= wr_data;
            if (idx == LAST_IDX) state <= PEND;
            else                 idx   <= idx + IDX_W'(1);
          end
        end
        PEND: begin
          // A sync edge wins over a simultaneous reload request.
          if (vs_rise) begin
            for (int k = 0; k < NUM_COEFF; k++) active[k] <= shadow[k];
            update_done <= 1'b1;
            state       <= IDLE;
          end else if (load_start) begin
            state <= LOAD;
            idx   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wr_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign pending  = (state == PEND);

  for (genvar k = 0; k < NUM_COEFF; k++) begin : g_pack
    assign coeff_o[k*COEFF_W +: COEFF_W] = active[k];
  end

endmodule

// File: doc/fir_coeff_ctrl.md
FIR_COEFF_CTRL -- requirements
Module: fir_coeff_ctrl

Interface
REQ-001 SHALL have parameter NUM_COEFF, default 25, number of coefficients in the 5x5 kernel (row-major, index k = row*5 + col).
REQ-002 SHALL have parameter COEFF_W, default 16, signed coefficient width.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port load_start  input  1  single-cycle request to begin loading a new kernel.
REQ-006 SHALL have port wr_valid  input  1  coefficient word valid.
REQ-007 SHALL have port wr_data  input  COEFF_W  signed coefficient word, sent in index order 0..NUM_COEFF-1.
REQ-008 SHALL have port wr_ready  output  1  word accepted when wr_valid && wr_ready.
REQ-009 SHALL have port vs_i  input  1  vertical sync of the video stream feeding the filter.
REQ-010 SHALL have port coeff_o  output  NUM_COEFF*COEFF_W  active kernel; coefficient k on bits [k*COEFF_W +: COEFF_W].
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port pending  output  1  high while state is PEND.
REQ-013 SHALL have port update_done  output  1  one-cycle pulse in the first cycle coeff_o shows a new kernel.

Function
REQ-014 SHALL hold two banks: shadow (written by loader) and active (drives coeff_o); coeff_o SHALL come directly from active registers.
REQ-015 SHALL implement FSM states IDLE, LOAD, PEND.
REQ-016 IDLE: load_start -> LOAD next cycle, word index cleared to 0.
REQ-017 LOAD: wr_ready = 1; each accepted word written to shadow[index], index incremented.
REQ-018 LOAD: accept of word at index NUM_COEFF-1 -> PEND next cycle; wr_ready low from that next cycle.
REQ-019 LOAD: load_start ignored; vs_i rising edges ignored (no bank swap).
REQ-020 PEND: on detected vs_i rising edge, active <= shadow in one step (all NUM_COEFF together), state -> IDLE; coeff_o and update_done change on the same clock edge.
REQ-021 vs_i rising edge SHALL be detected as vs_i==1 and previous-cycle vs_i==0 via one register; new kernel visible 1 cycle after the sampled edge cycle.
REQ-022 PEND: load_start -> LOAD, index reset to 0, pending shadow discarded (overwritten), no swap.
REQ-023 PEND: load_start and vs_i edge in same cycle -> swap takes priority; load_start dropped.
REQ-024 Final word accept and vs_i edge in same cycle -> no swap that frame; swap at next vs_i rising edge.
REQ-025 wr_valid outside LOAD SHALL have no effect; wr_data never partially applied to active bank.
REQ-026 wr_ready SHALL be 0 in IDLE and PEND.
REQ-027 Active bank SHALL never change except per REQ-020 or reset.
REQ-028 Unity gain coefficient SHALL be 16'h0100 (datapath computes pixel*coeff/256).

Reset
REQ-029 rst SHALL force state IDLE, index 0, vs edge register 0, shadow all 0.
REQ-030 rst SHALL load active with identity kernel: index 12 = 16'h0100, all others 0.
REQ-031 Outputs after reset: wr_ready 0, busy 0, pending 0, update_done 0, coeff_o identity.
REQ-032 rst asserted mid-LOAD or in PEND SHALL abandon the load; no partial or pending kernel ever reaches coeff_o.

Verification
REQ-033 Reset: assert rst 2 cycles -> coeff_o bits [207:192]=16'h0100, all other fields 0; busy=0, wr_ready=0.
REQ-034 Full load + swap: load_start, 25 words 1..25 with wr_valid constant -> pending=1 after 25th accept, coeff_o unchanged; vs_i 0->1 -> next cycle coeff_o field k = k+1, update_done one pulse, busy=0.
REQ-035 Backpressure/gaps: wr_valid toggled randomly during LOAD, vs_i pulses mid-load -> no swap during LOAD, final kernel matches sent order exactly.
REQ-036 Reload in PEND: complete load of all 7s, then load_start, then load all -3 (16'hFFFD), vs_i edge -> coeff_o all 16'hFFFD; 7s never observed.
REQ-037 Simultaneous events: 25th accept coincident with vs_i edge -> no swap; next edge swaps. In PEND, load_start coincident with vs_i edge -> swap occurs, state IDLE.
REQ-038 Reset mid-operation: rst after 10 words, and separately in PEND -> coeff_o identity, pending=0, subsequent vs_i edges cause no update_done.
